// File: rtl/snake_cell_render.sv
// rtl/snake_cell_render.sv - clears the frame after reset, then blanks the tail cell and paints the head cell one pixel per clock
module snake_cell_render #(
    parameter int         CELL     = 4,
    parameter int         SCREEN_W = 160,
    parameter int         SCREEN_H = 120,
    parameter logic [8:0] BG_COLOR = 9'b0
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    input  logic [7:0] tail_x,
    input  logic [6:0] tail_y,
    input  logic       erase_tail,
    input  logic [8:0] color,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [8:0] VGA_COLOR,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int LW = $clog2(CELL);
    localparam int KW = 2 * LW;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [7:0]    X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0]    Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [7:0]    X_MASK = ~8'(CELL - 1);
    localparam logic [6:0]    Y_MASK = ~7'(CELL - 1);

    typedef enum logic [2:0] {
        S_CLEAR_INIT = 3'd0,
        S_CLEAR      = 3'd1,
        S_IDLE       = 3'd2,
        S_ERASE      = 3'd3,
        S_DRAW       = 3'd4,
        S_FIN        = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    cx_q, cx_d;
    logic [6:0]    cy_q, cy_d;
    logic [7:0]    hx_q, hx_d, tx_q, tx_d;
    logic [6:0]    hy_q, hy_d, ty_q, ty_d;
    logic          erase_q, erase_d;
    logic [8:0]    color_q, color_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [8:0]    col_q, col_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    pix_x;
    logic [6:0]    pix_y;

    // Cell origin is the aligned base; the offset counter walks dx fastest.
    always_comb begin
        if (state_q == S_ERASE) begin
            pix_x = (tx_q & X_MASK) + 8'(k_q[LW-1:0]);
            pix_y = (ty_q & Y_MASK) + 7'(k_q[KW-1:LW]);
        end else begin
            pix_x = (hx_q & X_MASK) + 8'(k_q[LW-1:0]);
            pix_y = (hy_q & Y_MASK) + 7'(k_q[KW-1:LW]);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        erase_d = erase_q;
        color_d = color_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_CLEAR_INIT: begin
                state_d = S_CLEAR;
                cx_d    = '0;
                cy_d    = '0;
            end
            S_CLEAR: begin
                x_d    = cx_q;
                y_d    = cy_q;
                col_d  = BG_COLOR;
                plot_d = 1'b1;
                busy_d = 1'b1;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_IDLE: begin
                if (start) begin
                    hx_d    = head_x;
                    hy_d    = head_y;
                    tx_d    = tail_x;
                    ty_d    = tail_y;
                    erase_d = erase_tail;
                    color_d = color;
                    k_d     = '0;
                    state_d = erase_tail ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE, S_DRAW: begin
                x_d    = pix_x;
                y_d    = pix_y;
                col_d  = (state_q == S_ERASE) ? BG_COLOR : color_q;
                // Off-screen pixels still take their cycle so latency stays fixed.
                plot_d = (pix_x <= X_LAST) && (pix_y <= Y_LAST);
                busy_d = 1'b1;
                k_d    = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = (state_q == S_ERASE) ? S_DRAW : S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_CLEAR_INIT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= S_CLEAR_INIT;
            k_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            hx_q    <= '0;
            hy_q    <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            erase_q <= 1'b0;
            color_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            erase_q <= erase_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign VGA_X     = x_q;
    assign VGA_Y     = y_q;
    assign VGA_COLOR = col_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_snake_cell_render.sv
// tb/tb_snake_cell_render.sv - directed and random renders checked against a pixel-list model
module tb_snake_cell_render;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] head_x, tail_x;
    logic [6:0] head_y, tail_y;
    logic       erase_tail;
    logic [8:0] color;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [8:0] VGA_COLOR;
    logic       plot, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    snake_cell_render dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .tail_x    (tail_x),
        .tail_y    (tail_y),
        .erase_tail(erase_tail),
        .color     (color),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {VGA_X, VGA_Y, VGA_COLOR, plot, busy, done}, 64'd0);
    endtask

    // Full-frame clear: every pixel of the screen in raster order, background colour.
    task automatic check_clear();
        int c;
        c = 0;
        while (plot !== 1'b1 && c < 5) begin
            @(negedge clk);
            c++;
        end
        chk("clear_first_plot_seen", {63'd0, plot}, 64'd1);
        for (int i = 0; i < 160 * 120; i++) begin
            chk("clear_pixel",
                {37'd0, busy, done, plot, VGA_X, VGA_Y, VGA_COLOR},
                {37'd0, 1'b1, 1'b0, 1'b1, 8'(i % 160), 7'(i / 160), 9'd0});
            @(negedge clk);
        end
        chk("clear_end", {61'd0, plot, busy, done}, 64'd0);
        @(negedge clk);
        chk("clear_no_done", {61'd0, plot, busy, done}, 64'd0);
    endtask

    // Render one move. inject: re-assert start mid-render; rst_at: pull reset after that pixel.
    task automatic render(input int hx, input int hy, input int tx, input int ty,
                          input bit er, input logic [8:0] col, input bit inject, input int rst_at);
        int         ex[$];
        int         ey[$];
        logic [8:0] ec[$];
        int         bx, by, n;
        bit         ep;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0 && !er) continue;
            bx = (pass == 0) ? tx : hx;
            by = (pass == 0) ? ty : hy;
            bx = bx - (bx % 4);
            by = by - (by % 4);
            for (int dy = 0; dy < 4; dy++)
                for (int dx = 0; dx < 4; dx++) begin
                    ex.push_back(bx + dx);
                    ey.push_back(by + dy);
                    ec.push_back(pass == 0 ? 9'd0 : col);
                end
        end
        n = ex.size();

        head_x = 8'(hx); head_y = 7'(hy); tail_x = 8'(tx); tail_y = 7'(ty);
        erase_tail = er; color = col; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        head_x = 8'($urandom); head_y = 7'($urandom); tail_x = 8'($urandom);
        tail_y = 7'($urandom); erase_tail = 1'($urandom); color = 9'($urandom);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            ep = (ex[c-1] < 160) && (ey[c-1] < 120);
            chk("render_pixel",
                {37'd0, busy, done, plot, VGA_X, VGA_Y, ep ? VGA_COLOR : 9'd0},
                {37'd0, 1'b1, 1'b0, ep, 8'(ex[c-1] % 256), 7'(ey[c-1] % 128), ep ? ec[c-1] : 9'd0});
            start = inject && (c == 2 || c == 9);
            if (rst_at == c) begin
                resetn = 1'b0;
                start  = 1'b0;
                @(negedge clk);
                chk_zero("reset_mid_render");
                @(negedge clk);
                chk_zero("reset_held_no_done");
                return;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("render_done", {61'd0, plot, busy, done}, 64'd1);
        @(negedge clk);
        chk("render_done_single", {61'd0, plot, busy, done}, 64'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; erase_tail = 1'b0; color = '0;
        head_x = '0; head_y = '0; tail_x = '0; tail_y = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        resetn = 1'b1;
        @(negedge clk);
        chk_zero("clear_init_idle_outputs");
        check_clear();

        render(8, 12, 0, 0, 1'b0, 9'o070, 1'b0, 0);
        render(4, 0, 0, 0, 1'b1, 9'h1FF, 1'b0, 0);
        render(158, 117, 40, 40, 1'b0, 9'h0AA, 1'b0, 0);
        render(160, 0, 0, 0, 1'b0, 9'h155, 1'b0, 0);
        render(20, 20, 20, 20, 1'b1, 9'h123, 1'b0, 0);
        render(100, 60, 0, 0, 1'b0, 9'h0F0, 1'b1, 0);
        render(100, 60, 96, 60, 1'b1, 9'h00F, 1'b1, 0);
        render(200, 125, 156, 116, 1'b1, 9'h1C0, 1'b0, 0);

        for (int r = 0; r < 10; r++)
            render($urandom_range(0, 255), $urandom_range(0, 127),
                   $urandom_range(0, 255), $urandom_range(0, 127),
                   1'($urandom), 9'($urandom), 1'($urandom), 0);

        render(40, 40, 36, 40, 1'b0, 9'h1AB, 1'b0, 7);
        resetn = 1'b1;
        @(negedge clk);
        chk_zero("restart_clear_init");
        check_clear();
        render(12, 8, 8, 8, 1'b1, 9'h0C3, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
